// File: rtl/instr_prefetch_buf.sv
// rtl/instr_prefetch_buf.sv - in-order instruction prefetch buffer with redirect flush
// Optional IPF_STALL_CNT_EN adds a saturating stall_cycles counter output.
module instr_prefetch_buf #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready
`ifdef IPF_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, outstanding, drop_cnt;
   logic [31:0]   fetch_pc, resp_pc, redirect_base;
   logic [CW:0]   credit_used;
   logic          grant, resp, push, pop;

   // Entries already in the FIFO plus fetches in flight may never exceed DEPTH.
   assign credit_used   = {1'b0, count} + {1'b0, outstanding};
   assign imem_req      = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr     = fetch_pc;
   assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

   assign grant    = imem_req && imem_gnt;
   assign resp     = imem_rvalid && (outstanding != '0);
   assign push     = resp && (drop_cnt == '0);
   assign if_valid = (count != '0);
   assign pop      = if_valid && if_ready;
   assign if_pc    = if_valid ? pc_mem[rd_ptr]    : 32'h0;
   assign if_instr = if_valid ? instr_mem[rd_ptr] : 32'h0;

   always_ff @(posedge clk) begin
      if (!reset && !redirect_valid && push) begin
         pc_mem[wr_ptr]    <= resp_pc;
         instr_mem[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
      end else begin
         outstanding <= outstanding + CW'(grant) - CW'(resp);
         if (redirect_valid) begin
            // Whatever is still in flight after this cycle's response belongs to the old path.
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            drop_cnt <= outstanding - CW'(resp);
         end else begin
            if (grant)
               fetch_pc <= fetch_pc + 32'd4;
            if (resp) begin
               if (drop_cnt != '0) begin
                  drop_cnt <= drop_cnt - CW'(1);
               end else begin
                  wr_ptr  <= wr_ptr + PW'(1);
                  resp_pc <= resp_pc + 32'd4;
               end
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef IPF_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles <= 32'h0;
      else if (if_ready && !if_valid && !redirect_valid && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// tb/tb_instr_prefetch_buf.sv - randomized bench for instr_prefetch_buf against a queue-based model
module tb_instr_prefetch_buf;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, redirect_valid, imem_req, imem_gnt, imem_rvalid;
   logic        if_valid, if_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, if_pc, if_instr;
`ifdef IPF_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   always #5 clk = ~clk;

   instr_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
`ifdef IPF_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          gcyc;
      bit          stale;
   } fetch_t;

   fetch_t      inflight[$];
   logic [31:0] fq_pc[$];
   logic [31:0] fq_ins[$];
   logic [31:0] m_fetch;
   logic [31:0] m_stall;
   int          cyc;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      if_ready       = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
`ifdef IPF_STALL_CNT_EN
      chk("rst_stall", stall_cycles, 32'h0);
`endif
      reset = 1'b0;
      inflight.delete();
      fq_pc.delete();
      fq_ins.delete();
      m_fetch = RESET_PC;
      m_stall = 32'h0;
   endtask

   initial begin
      int p_gnt, p_rv, p_rdy, p_redir;
      bit exp_req, grant, resp, fq_empty;
      fetch_t e;
      cyc = 0;
      do_reset();
      for (int c = 1; c <= 3000; c++) begin
         cyc = c;
         if (c == 1500) do_reset();
         if (c <= 30)      begin p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0; end
         else if (c <= 60) begin p_gnt = 100; p_rv = 100; p_rdy = 0;   p_redir = 0; end
         else              begin p_gnt = 70;  p_rv = 60;  p_rdy = 60;  p_redir = 6; end

         // Drive this cycle's inputs (we sit on a negedge).
         redirect_valid = ($urandom_range(99) < p_redir);
         case ($urandom_range(2))
            0:       redirect_pc = 32'h0000_0103;
            1:       redirect_pc = 32'hFFFF_FFF8;
            default: redirect_pc = $urandom;
         endcase
         imem_gnt    = ($urandom_range(99) < p_gnt);
         if_ready    = ($urandom_range(99) < p_rdy);
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (inflight.size() > 0) begin
            if (inflight[0].gcyc < cyc && $urandom_range(99) < p_rv) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(inflight[0].addr);
            end
         end else if ($urandom_range(9) == 0) begin
            imem_rvalid = 1'b1;
         end
         #1;

         fq_empty = (fq_pc.size() == 0);
         exp_req  = !redirect_valid && (fq_pc.size() + inflight.size() < DEPTH);
         chk("imem_req", 32'(imem_req), 32'(exp_req));
         if (exp_req) chk("imem_addr", imem_addr, m_fetch);
         chk("if_valid", 32'(if_valid), 32'(!fq_empty));
         chk("if_pc", if_pc, fq_empty ? 32'h0 : fq_pc[0]);
         chk("if_instr", if_instr, fq_empty ? 32'h0 : fq_ins[0]);
`ifdef IPF_STALL_CNT_EN
         chk("stall_cycles", stall_cycles, m_stall);
         if (if_ready && fq_empty && !redirect_valid && m_stall != 32'hFFFF_FFFF)
            m_stall = m_stall + 32'd1;
`endif

         grant = exp_req && imem_gnt;
         resp  = imem_rvalid && (inflight.size() > 0);
         if (redirect_valid) begin
            if (resp) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            fq_pc.delete();
            fq_ins.delete();
            m_fetch = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (!fq_empty && if_ready) begin
               void'(fq_pc.pop_front());
               void'(fq_ins.pop_front());
            end
            if (resp) begin
               e = inflight.pop_front();
               if (!e.stale) begin
                  fq_pc.push_back(e.addr);
                  fq_ins.push_back(mem_word(e.addr));
               end
            end
            if (grant) begin
               inflight.push_back('{addr: m_fetch, gcyc: cyc, stale: 1'b0});
               m_fetch = m_fetch + 32'd4;
            end
         end
         @(negedge clk);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
